// File: rtl/front_layer_ctrl.sv
// C1 front-layer sequencer: weight load, 28x28 convolution sweep, done.
// Drives the one-hot state bus, column/row counters and output framing.
module front_layer_ctrl #(
  parameter int FILTER_WIDTH       = 5,
  parameter int INPUT_WIDTH        = 32,
  parameter int OUTPUT_FEATURE_MAP = 6,
  parameter int W_DEPTH            = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [4:0] st,
  output logic [4:0] in_cell_row,
  output logic [4:0] out_row,
  output logic       out_valid,
  output logic       busy,
  output logic       done
);

  localparam int W_LOAD_CYCLES = OUTPUT_FEATURE_MAP * W_DEPTH + 1;
  localparam int OUT_DIM_I     = INPUT_WIDTH - FILTER_WIDTH + 1;

  localparam logic [7:0] W_LAST   = 8'(W_LOAD_CYCLES - 1);
  localparam logic [4:0] OUT_DIM  = 5'(OUT_DIM_I);
  localparam logic [4:0] ROW_LAST = 5'(OUT_DIM_I - 1);

  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    LOAD_W = 5'b00010,
    CALC   = 5'b00100,
    DONE   = 5'b01000
  } state_t;

  state_t     r_st;
  state_t     w_st_n;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_n;
  logic [4:0] r_col;
  logic [4:0] w_col_n;
  logic [4:0] r_row;
  logic [4:0] w_row_n;
  logic       r_valid;
  logic       r_busy;
  logic       r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st    <= IDLE;
      r_cnt   <= 8'd0;
      r_col   <= 5'd0;
      r_row   <= 5'd0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_st    <= w_st_n;
      r_cnt   <= w_cnt_n;
      r_col   <= w_col_n;
      r_row   <= w_row_n;
      r_valid <= (w_st_n == CALC) && (w_col_n < OUT_DIM);
      r_busy  <= (w_st_n != IDLE);
      r_done  <= (w_st_n == DONE);
    end
  end

  // Counters default to zero so every non-CALC state parks them at 0.
  always_comb begin
    w_st_n  = r_st;
    w_cnt_n = 8'd0;
    w_col_n = 5'd0;
    w_row_n = 5'd0;
    case (r_st)
      IDLE: begin
        if (start) w_st_n = LOAD_W;
      end
      LOAD_W: begin
        if (r_cnt >= W_LAST) w_st_n = CALC;
        else w_cnt_n = r_cnt + 8'd1;
      end
      CALC: begin
        if (r_col >= OUT_DIM) begin
          if (r_row >= ROW_LAST) w_st_n = DONE;
          else w_row_n = r_row + 5'd1;
        end else begin
          w_col_n = r_col + 5'd1;
          w_row_n = r_row;
        end
      end
      DONE:    w_st_n = IDLE;
      default: w_st_n = IDLE;
    endcase
  end

  assign st          = r_st;
  assign in_cell_row = r_col;
  assign out_row     = r_row;
  assign out_valid   = r_valid;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_front_layer_ctrl.sv
// Bench for front_layer_ctrl: timeline model feeds an expected-value queue,
// compared 1ns after each posedge.
module tb_front_layer_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] st;
  logic [4:0] in_cell_row;
  logic [4:0] out_row;
  logic       out_valid;
  logic       busy;
  logic       done;

  front_layer_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .st         (st),
    .in_cell_row(in_cell_row),
    .out_row    (out_row),
    .out_valid  (out_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int m_n   = 0;
  int vcnt  = 0;
  int lcnt  = 0;
  logic [17:0] sb_q[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected outputs from run offset n (cycles since start was sampled).
  function automatic logic [17:0] model(input int n);
    logic [4:0] s;
    logic [4:0] c;
    logic [4:0] r;
    logic       v;
    int         idx;
    s = 5'b00001; c = 0; r = 0; v = 0;
    if (n >= 1 && n <= 157) s = 5'b00010;
    else if (n >= 158 && n <= 969) begin
      s   = 5'b00100;
      idx = n - 158;
      c   = 5'(idx % 29);
      r   = 5'(idx / 29);
      v   = (idx % 29) < 28;
    end else if (n == 970) s = 5'b01000;
    return {s, c, r, v, n != 0, n == 970};
  endfunction

  task automatic cyc(input logic r, input logic s);
    logic [17:0] exp;
    logic [17:0] got;
    rst   = r;
    start = s;
    @(posedge clk);
    if (r) m_n = 0;
    else if (m_n == 0) m_n = s ? 1 : 0;
    else if (m_n == 970) m_n = 0;
    else m_n = m_n + 1;
    sb_q.push_back(model(m_n));
    #1;
    exp = sb_q.pop_front();
    got = {st, in_cell_row, out_row, out_valid, busy, done};
    chk("outs", 32'(got), 32'(exp));
    if (m_n == 1) begin vcnt = 0; lcnt = 0; end
    if (out_valid) vcnt++;
    if (st == 5'b00010) lcnt++;
    if (m_n == 970) begin
      chk("valid_cnt", 32'(vcnt), 32'd784);
      chk("loadw_cnt", 32'(lcnt), 32'd157);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    // Reset, idle
    cyc(1, 0);
    cyc(1, 0);
    chk("rst_st", 32'(st), 32'h01);
    chk("rst_busy", 32'(busy), 32'h0);
    for (int i = 0; i < 4; i++) cyc(0, 0);
    // Single pulse, full run, then back-to-back start on the IDLE cycle
    cyc(0, 1);
    for (int i = 0; i < 970; i++) cyc(0, 0);
    chk("idle_after", 32'(st), 32'h01);
    cyc(0, 1);
    for (int i = 0; i < 972; i++) cyc(0, 0);
    // start held high across two runs
    for (int i = 0; i < 2 * 971 + 5; i++) cyc(0, 1);
    for (int i = 0; i < 975; i++) cyc(0, 0);
    // Reset mid-CALCULATION at row 13, col 7
    cyc(0, 1);
    for (int i = 0; i < 541; i++) cyc(0, 0);
    chk("mid_row", 32'(out_row), 32'd13);
    chk("mid_col", 32'(in_cell_row), 32'd7);
    cyc(1, 0);
    chk("mid_rst_st", 32'(st), 32'h01);
    chk("mid_rst_v", 32'(out_valid), 32'h0);
    cyc(0, 0);
    cyc(0, 1);
    for (int i = 0; i < 975; i++) cyc(0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
